// File: rtl/apple1_pkg.sv
// rtl/apple1_pkg.sv - Shared rate-select encodings and default divisors for the Apple-1 system controller
package apple1_pkg;

  localparam logic [1:0] MODE_NORM  = 2'b00;
  localparam logic [1:0] MODE_SLOW  = 2'b01;
  localparam logic [1:0] MODE_TURBO = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

  localparam int NORM_DIV_DEF = 25;
  localparam int SLOW_DIV_DEF = 25000000;

endpackage

// File: rtl/apple1_clken_div.sv
// rtl/apple1_clken_div.sv - CPU clock-enable divider with clean restart on rate change and single-step pulse
module apple1_clken_div
  import apple1_pkg::*;
#(
  parameter int CNT_W    = 25,
  parameter int DIV_W    = 25,
  parameter int INIT_DIV = NORM_DIV_DEF
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             enable_free,
  input  logic             step_pulse,
  output logic             cpu_clken
);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_q;
  logic             free_q;
  logic             clken_q, clken_d;
  logic             restart;

  // Any change of the effective rate parks the counter for one idle cycle,
  // so the new rate always begins with a full-width pulse.
  always_comb begin
    restart   = (divisor != div_q) || (enable_free != free_q);
    div_cnt_d = '0;
    clken_d   = 1'b0;
    if (!restart) begin
      if (enable_free) begin
        clken_d = (div_cnt_q == '0);
        if (DIV_W'(div_cnt_q) != divisor - DIV_W'(1)) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end else begin
        clken_d = step_pulse;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      div_q     <= DIV_W'(INIT_DIV);
      free_q    <= 1'b1;
      clken_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_q     <= divisor;
      free_q    <= enable_free;
      clken_q   <= clken_d;
    end
  end

  assign cpu_clken = clken_q;

endmodule

// File: rtl/apple1_sys_ctrl.sv
// rtl/apple1_sys_ctrl.sv - Apple-1 CPU clock-enable rate select, reset sequencer and debug cycle counter
module apple1_sys_ctrl
  import apple1_pkg::*;
#(
  parameter int NORM_DIV   = NORM_DIV_DEF,
  parameter int SLOW_DIV   = SLOW_DIV_DEF,
  parameter int RST_CYCLES = 63,
  parameter int CYC_W      = 32
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic             soft_rst_req,
  output logic             cpu_clken,
  output logic             cpu_reset,
  output logic             rst_done,
  output logic [CYC_W-1:0] cyc_count
);

  localparam int CNT_W = $clog2(SLOW_DIV);
  localparam int DIV_W = $clog2(SLOW_DIV + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  logic [DIV_W-1:0] divisor;
  logic             enable_free;
  logic             step_pulse;
  logic             step_q;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             cpu_reset_q;
  logic             rst_done_q;
  logic [CYC_W-1:0] cyc_count_q;

  // The reset sequence always runs at the normal rate, whatever mode is selected.
  always_comb begin
    divisor     = DIV_W'(NORM_DIV);
    enable_free = 1'b1;
    if (rst_done_q) begin
      case (mode)
        MODE_SLOW:  divisor = DIV_W'(SLOW_DIV);
        MODE_TURBO: divisor = DIV_W'(1);
        MODE_STEP:  enable_free = 1'b0;
        default:    divisor = DIV_W'(NORM_DIV);
      endcase
    end
  end

  assign step_pulse = rst_done_q && (mode == MODE_STEP) && step_req && !step_q;

  apple1_clken_div #(
    .CNT_W   (CNT_W),
    .DIV_W   (DIV_W),
    .INIT_DIV(NORM_DIV)
  ) u_div (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .enable_free(enable_free),
    .step_pulse (step_pulse),
    .cpu_clken  (cpu_clken)
  );

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      rst_cnt_q   <= '0;
      cpu_reset_q <= 1'b1;
      rst_done_q  <= 1'b0;
      cyc_count_q <= '0;
    end else begin
      step_q <= step_req;
      if (soft_rst_req) begin
        rst_cnt_q   <= '0;
        cpu_reset_q <= 1'b1;
        rst_done_q  <= 1'b0;
        cyc_count_q <= '0;
      end else if (cpu_clken) begin
        if (rst_cnt_q == RC_W'(RST_CYCLES)) begin
          cpu_reset_q <= 1'b0;
          rst_done_q  <= 1'b1;
        end else begin
          rst_cnt_q <= rst_cnt_q + 1'b1;
        end
        if (rst_done_q) begin
          cyc_count_q <= cyc_count_q + 1'b1;
        end
      end
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign rst_done  = rst_done_q;
  assign cyc_count = cyc_count_q;

endmodule

// File: tb/tb_apple1_sys_ctrl.sv
// tb/tb_apple1_sys_ctrl.sv - Self-checking bench for apple1_sys_ctrl against a pulse-counting reference model
module tb_apple1_sys_ctrl;
  import apple1_pkg::*;

  localparam int     NDIV = 25;
  localparam int     SDIV = 25000000;
  localparam int     RSTC = 63;
  localparam longint SEQ  = RSTC + 1;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = MODE_NORM;
  logic        step_req = 1'b0;
  logic        soft_rst_req = 1'b0;
  logic        cpu_clken, cpu_reset, rst_done;
  logic [31:0] cyc_count;
  logic        cpu_clken4, cpu_reset4, rst_done4;
  logic [3:0]  cyc_count4;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk25 = ~clk25;

  apple1_sys_ctrl dut (
    .clk25(clk25), .rst_n(rst_n), .mode(mode), .step_req(step_req),
    .soft_rst_req(soft_rst_req), .cpu_clken(cpu_clken), .cpu_reset(cpu_reset),
    .rst_done(rst_done), .cyc_count(cyc_count)
  );

  apple1_sys_ctrl #(.CYC_W(4)) dut4 (
    .clk25(clk25), .rst_n(rst_n), .mode(mode), .step_req(step_req),
    .soft_rst_req(soft_rst_req), .cpu_clken(cpu_clken4), .cpu_reset(cpu_reset4),
    .rst_done(rst_done4), .cyc_count(cyc_count4)
  );

  // Reference: m_k counts accepted enables since the sequence (re)started;
  // m_s counts edges since the last rate change.
  longint m_k = 0;
  longint m_s = 0;
  int     m_cfg = NDIV;
  logic   m_clken = 1'b0;
  logic   m_step_prev = 1'b0;

  logic        e_done, e_reset;
  logic [31:0] e_cyc;
  assign e_done  = (m_k >= SEQ);
  assign e_reset = !e_done;
  assign e_cyc   = e_done ? 32'(m_k - SEQ) : 32'd0;

  function automatic int rate_of(input logic [1:0] md, input logic done);
    if (!done) return NDIV;
    case (md)
      MODE_SLOW:  return SDIV;
      MODE_TURBO: return 1;
      MODE_STEP:  return 0;
      default:    return NDIV;
    endcase
  endfunction

  always @(posedge clk25 or negedge rst_n) begin : model
    int     cfg;
    longint s;
    if (!rst_n) begin
      m_k         <= 0;
      m_s         <= 0;
      m_cfg       <= NDIV;
      m_clken     <= 1'b0;
      m_step_prev <= 1'b0;
    end else begin
      cfg = rate_of(mode, e_done);
      if (cfg != m_cfg) begin
        s = 0;
        m_clken <= 1'b0;
      end else begin
        s = m_s + 1;
        if (cfg == 0) m_clken <= step_req && !m_step_prev;
        else          m_clken <= ((s - 1) % cfg) == 0;
      end
      m_s         <= s;
      m_cfg       <= cfg;
      m_step_prev <= step_req;
      if (soft_rst_req) m_k <= 0;
      else if (m_clken) m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk25) begin
    if (rst_n) begin
      check("clken", cpu_clken, m_clken);
      check("cpu_reset", cpu_reset, e_reset);
      check("rst_done", rst_done, e_done);
      check("cyc_count", cyc_count, e_cyc);
      check("clken_w4", cpu_clken4, m_clken);
      check("cyc_count_w4", cyc_count4, e_cyc[3:0]);
    end
  end

  task automatic tick();
    @(negedge clk25);
  endtask

  task automatic count_to_done(input int limit, input bit toggle, output int pulses);
    pulses = 0;
    for (int i = 0; i < limit && !rst_done; i++) begin
      if (cpu_clken) pulses++;
      if (toggle && (i % 5 == 0)) step_req = ~step_req;
      tick();
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_clken) pulses++;
    end
  endtask

  task automatic wait_pulses(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 2000 && seen < n; i++) begin
      tick();
      if (cpu_clken) seen++;
    end
  endtask

  task automatic gap_to_next(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!cpu_clken && gap < 200);
  endtask

  initial begin
    int n, m, g;
    logic [31:0] c0;

    repeat (2) tick();
    check("rst_clken", cpu_clken, 1'b0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_done_low", rst_done, 1'b0);
    check("rst_cyc", cyc_count, 32'd0);
    check("rst_cyc_w4", cyc_count4, 4'd0);
    #2 rst_n = 1'b1;

    tick();
    check("first_pulse", cpu_clken, 1'b1);
    count_to_done(3000, 1'b0, n);
    check("pwrup_pulses", n, 64);
    check("cyc_at_done", cyc_count, 32'd0);
    gap_to_next(g);
    gap_to_next(g);
    check("norm_period", g, 25);
    check("cyc_after_65", cyc_count, 32'd1);
    wait_pulses(18);
    tick();
    check("cyc_20", cyc_count, 32'd20);
    check("cyc_w4_wrap", cyc_count4, 4'd4);

    mode = MODE_TURBO;
    tick();
    check("turbo_idle", cpu_clken, 1'b0);
    count_pulses(6, n);
    check("turbo_every", n, 6);
    mode = MODE_NORM;
    tick();
    check("norm_idle", cpu_clken, 1'b0);
    tick();
    check("norm_restart_pulse", cpu_clken, 1'b1);
    gap_to_next(g);
    check("norm_period_after_turbo", g, 25);

    mode = MODE_TURBO;
    for (int i = 0; i < 3000 && e_cyc != 32'd1000; i++) tick();
    check("cyc_1000", cyc_count, 32'd1000);
    soft_rst_req = 1'b1;
    tick();
    check("soft_cpu_reset", cpu_reset, 1'b1);
    check("soft_rst_done", rst_done, 1'b0);
    check("soft_cyc", cyc_count, 32'd0);
    repeat (2) tick();
    soft_rst_req = 1'b0;
    count_to_done(3000, 1'b0, n);
    check("soft_pulses", n, 64);

    mode = MODE_STEP;
    repeat (3) tick();
    c0 = e_cyc;
    step_req = 1'b1;
    tick();
    check("step1_next_cycle", cpu_clken, 1'b1);
    n = 1;
    count_pulses(9, m);
    n += m;
    step_req = 1'b0;
    count_pulses(3, m);
    n += m;
    step_req = 1'b1;
    tick();
    check("step2_next_cycle", cpu_clken, 1'b1);
    n++;
    count_pulses(3, m);
    n += m;
    step_req = 1'b0;
    count_pulses(2, m);
    n += m;
    check("step_pulses", n, 2);
    check("step_cyc", cyc_count, c0 + 32'd2);

    mode = MODE_SLOW;
    tick();
    check("slow_idle", cpu_clken, 1'b0);
    tick();
    check("slow_first", cpu_clken, 1'b1);
    count_pulses(200, n);
    check("slow_quiet", n, 0);

    tick();
    #5 rst_n = 1'b0;
    #1;
    check("async_clken", cpu_clken, 1'b0);
    check("async_cpu_reset", cpu_reset, 1'b1);
    check("async_rst_done", rst_done, 1'b0);
    check("async_cyc", cyc_count, 32'd0);
    check("async_cyc_w4", cyc_count4, 4'd0);
    mode = MODE_STEP;
    tick();
    #2 rst_n = 1'b1;
    count_to_done(3000, 1'b1, n);
    check("step_pwrup_pulses", n, 64);
    step_req = 1'b0;
    count_pulses(50, n);
    check("step_no_free", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
